// File: rtl/code_mem_arbiter_pkg.sv
// code_mem_arbiter_pkg: shared types for the code RAM arbiter.
// Exports the RAM slot owner encoding and the code read latency.
`ifndef IPR_WIDTH
`define IPR_WIDTH 16
`endif

package code_mem_arbiter_pkg;

    localparam int CODE_RD_LATENCY = 1;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_HOST_RD,
        OWN_HOST_WR
    } owner_e;

endpackage

// File: rtl/code_mem_arbiter.sv
// code_mem_arbiter: shares one single-port sync code RAM between the
// core fetch port and a host port, with cycle stealing and freeze mode.
// Ports: sysclk/sysreset_n; cpu_code_addr/in/ready (fetch side);
// host_req/we/addr/wdata/gnt/rvalid/rdata (host side); freeze;
// mem_addr/we/wdata/rdata (RAM side); stall_count (denied CPU cycles).
module code_mem_arbiter
    import code_mem_arbiter_pkg::*;
#(
    parameter int IPR_WIDTH       = `IPR_WIDTH,
    parameter int CPU_MIN_SLOTS   = 4,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       sysclk,
    input  logic                       sysreset_n,
    input  logic [IPR_WIDTH-1:0]       cpu_code_addr,
    output logic [15:0]                cpu_code_in,
    output logic                       cpu_code_ready,
    input  logic                       host_req,
    input  logic                       host_we,
    input  logic [IPR_WIDTH-1:0]       host_addr,
    input  logic [15:0]                host_wdata,
    output logic                       host_gnt,
    output logic                       host_rvalid,
    output logic [15:0]                host_rdata,
    input  logic                       freeze,
    output logic [IPR_WIDTH-1:0]       mem_addr,
    output logic                       mem_we,
    output logic [15:0]                mem_wdata,
    input  logic [15:0]                mem_rdata,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    localparam int CW = (CPU_MIN_SLOTS > 0) ?
                        $clog2(CPU_MIN_SLOTS + 1) : 1;
    localparam logic [CW-1:0] COOL_LOAD = CW'(CPU_MIN_SLOTS);

    logic [CW-1:0]              cool_q, cool_d;
    owner_e                     owner_q, owner_d;
    logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
    logic                       cpu_slot;

    // Gated by reset so nothing reaches the RAM while held in reset.
    assign host_gnt = sysreset_n & host_req &
                      (freeze | (cool_q == '0));
    assign cpu_slot = ~host_gnt & ~freeze;

    assign mem_addr  = host_gnt ? host_addr : cpu_code_addr;
    assign mem_we    = host_gnt & host_we;
    assign mem_wdata = host_wdata;

    // One RAM cycle of read latency: the owner of slot N qualifies
    // the shared read data in N+1.
    assign cpu_code_ready = (owner_q == OWN_CPU);
    assign host_rvalid    = (owner_q == OWN_HOST_RD) &&
                            (CODE_RD_LATENCY == 1);
    assign cpu_code_in    = mem_rdata;
    assign host_rdata     = mem_rdata;
    assign stall_count    = stall_q;

    always_comb begin
        owner_d = OWN_CPU;
        if (host_gnt) begin
            owner_d = host_we ? OWN_HOST_WR : OWN_HOST_RD;
        end else if (freeze) begin
            owner_d = OWN_NONE;
        end
    end

    always_comb begin
        cool_d = cool_q;
        if (freeze) begin
            cool_d = '0;
        end else if (host_gnt) begin
            cool_d = COOL_LOAD;
        end else if (cool_q != '0) begin
            cool_d = cool_q - 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!cpu_slot && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            owner_q <= OWN_NONE;
            cool_q  <= '0;
            stall_q <= '0;
        end else begin
            owner_q <= owner_d;
            cool_q  <= cool_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: doc/code_mem_arbiter.md
Name: code_mem_arbiter

Overview:
- Shares one single-port synchronous code RAM between the synapse316 instruction-fetch port and a host port (loader or debug supervisor).
- Generates the core's code_ready handshake from the grant schedule.
- Host accesses steal single RAM cycles. The CPU is guaranteed a minimum run of fetch slots between host accesses.
- Freeze mode gives the host every RAM cycle, for bulk program loads.

Parameters:
IPR_WIDTH, `IPR_WIDTH, code address width
CPU_MIN_SLOTS, 4, CPU-owned RAM cycles guaranteed after each non-freeze host grant (0 = host may take every cycle)
STALL_CNT_WIDTH, 16, width of the stolen-cycle counter

Ports:
sysclk  in  1  system clock, rising edge
sysreset_n  in  1  asynchronous active-low reset
cpu_code_addr  in  IPR_WIDTH  fetch address from core (core holds it stable while code_ready=0)
cpu_code_in  out  16  fetch data to core
cpu_code_ready  out  1  cpu_code_in is valid for the address presented in the previous cycle
host_req  in  1  host transaction valid
host_we  in  1  1=write, 0=read; qualified by host_req
host_addr  in  IPR_WIDTH  host address
host_wdata  in  16  host write data
host_gnt  out  1  combinational; host_req & host_gnt = transaction accepted this cycle
host_rvalid  out  1  host_rdata valid (one cycle after an accepted read)
host_rdata  out  16  host read data
freeze  in  1  host owns RAM every cycle; CPU is starved
mem_addr  out  IPR_WIDTH  RAM address (combinational mux)
mem_we  out  1  RAM write enable
mem_wdata  out  16  RAM write data
mem_rdata  in  16  RAM read data; 1-cycle latency after address sampled
stall_count  out  STALL_CNT_WIDTH  saturating count of cycles denied to the CPU

Behaviour:
- Reset (sysreset_n=0, async): cooldown=0, owner_q=NONE, cpu_code_ready=0, host_rvalid=0, stall_count=0. host_gnt=0 and mem_we=0 while reset is asserted.
- Grant, combinational in cycle N: host_gnt = host_req & (freeze | cooldown==0).
- If host_gnt: mem_addr=host_addr, mem_we=host_we, mem_wdata=host_wdata.
- Otherwise: mem_addr=cpu_code_addr, mem_we=0, and the slot is a CPU slot unless freeze=1.
- owner_q register, updated each edge: HOST_RD, HOST_WR, CPU or NONE (NONE = freeze with no host request).
- Cycle N+1 outputs from owner_q:
  - cpu_code_ready = (owner_q==CPU).
  - host_rvalid = (owner_q==HOST_RD).
  - cpu_code_in = host_rdata = mem_rdata (shared wires, qualified by the ready/valid flags).
- Read latency is exactly 1 for both ports. A write is complete at the grant edge; no response is returned.
- Cooldown counter:
  - Loads CPU_MIN_SLOTS on host_gnt & !freeze.
  - Decrements on each CPU slot while non-zero.
  - Holds otherwise.
  - Forced to 0 while freeze=1.
- Back-to-back host transactions are legal whenever host_gnt is high. Under freeze the host may issue one transaction every cycle.
- stall_count increments on every cycle that is not a CPU slot (host grant or freeze). It saturates at all-ones. It is cleared only by reset.
- Core-side rule: the core holds ipr while cpu_code_ready=0. A stolen cycle therefore re-fetches the same address on the next CPU slot; no fetch is lost or duplicated.
- Simultaneous events:
  - freeze rising with host_req: host granted that cycle.
  - freeze falling: the next cycle is a CPU slot unless host_req with cooldown==0.
- Host mid-transaction rule: host_req must hold addr, we and wdata stable until granted. Dropping req before grant cancels the transaction with no side effect.
- Reset mid-operation: in-flight read data is discarded (no rvalid). A pending host_req is re-evaluated after reset release with cooldown=0.

Decomposition:
- Shared package: owner enum (NONE, CPU, HOST_RD, HOST_WR) and a CODE_RD_LATENCY=1 constant.
- No sub-module. The cooldown counter and stall counter are inline.

Test Plan:
1. No host traffic, cpu_code_addr stepping 0,1,2,…; RAM preloaded mem[k]=0x1000+k -> cpu_code_ready=1 every cycle from the second cycle after reset; cpu_code_in=0x1000+k one cycle after addr k.
2. CPU_MIN_SLOTS=4, host_req held high with reads at 0x20,0x21 -> gnt at cycle N; rvalid with mem[0x20] at N+1; next gnt no earlier than N+5; cpu_code_ready=0 exactly at N+1 and the same CPU address re-fetched.
3. freeze=1, host writes 0xA5A5..0xA5AC to addresses 0..7 on consecutive cycles, then reads them back -> gnt every cycle; cpu_code_ready stays 0; rvalid data matches; stall_count=16.
4. Host write 0xBEEF to the address the CPU is currently fetching -> write takes the slot; CPU's subsequent ready cycle returns 0xBEEF.
5. Assert sysreset_n=0 in the cycle after an accepted host read -> host_rvalid never pulses; all outputs at reset values; after release with host_req still high, gnt is asserted in the first cycle.
6. Force stall_count near max (freeze for 2^STALL_CNT_WIDTH+3 cycles; use STALL_CNT_WIDTH=4 instance) -> count saturates at 0xF and holds.
